// File: rtl/mem_arbiter.sv
// mem_arbiter: single RAM port shared by instruction fetch and data access.
// Data wins arbitration; fetch is guaranteed a grant after FAIR_LIMIT data grants.
module mem_arbiter #(
  parameter int FAIR_LIMIT = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic [31:0] ramload,
  input  logic        ramready,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic        ihit,
  output logic        dhit,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        busy,
  output logic        timeout_err
);

  localparam int SW  = $clog2(FAIR_LIMIT + 1);
  localparam int TW0 = $clog2(TIMEOUT + 1);
  localparam int WW  = (TW0 > 8) ? TW0 : 8;

  typedef enum logic [1:0] {
    IDLE,
    IGRANT,
    DGRANT
  } state_t;

  state_t state;
  state_t stateNxt;

  logic [31:0]   addrQ;
  logic [31:0]   storeQ;
  logic          writeQ;
  logic [SW-1:0] dstreak;
  logic [WW-1:0] wcnt;
  logic          errQ;

  logic dReq;
  logic fairI;
  logic expired;
  logic granted;

  assign dReq    = dREN | dWEN;
  assign fairI   = iREN && (dstreak == SW'(FAIR_LIMIT));
  assign expired = (wcnt == WW'(TIMEOUT));
  assign granted = (state != IDLE);

  always_comb begin
    stateNxt = state;
    ihit     = 1'b0;
    dhit     = 1'b0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    unique case (state)
      IDLE: begin
        if (fairI)
          stateNxt = IGRANT;
        else if (dReq)
          stateNxt = DGRANT;
        else if (iREN)
          stateNxt = IGRANT;
      end
      IGRANT: begin
        ramREN = 1'b1;
        if (expired) begin
          stateNxt = IDLE;
        end else if (ramready) begin
          ihit     = nRST;
          stateNxt = IDLE;
        end else if (!iREN) begin
          stateNxt = IDLE;
        end
      end
      DGRANT: begin
        ramWEN = writeQ;
        ramREN = !writeQ;
        if (expired) begin
          stateNxt = IDLE;
        end else if (ramready) begin
          dhit     = nRST;
          stateNxt = IDLE;
        end else if (!dReq) begin
          stateNxt = IDLE;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state   <= IDLE;
      addrQ   <= '0;
      storeQ  <= '0;
      writeQ  <= 1'b0;
      dstreak <= '0;
      wcnt    <= '0;
      errQ    <= 1'b0;
    end else begin
      state <= stateNxt;
      if (!granted) begin
        wcnt <= '0;
        unique case (stateNxt)
          IGRANT: begin
            addrQ   <= iaddr;
            dstreak <= '0;
          end
          DGRANT: begin
            addrQ  <= daddr;
            storeQ <= dstore;
            writeQ <= dWEN;
            // only count data grants that made a fetch wait
            if (!iREN)
              dstreak <= '0;
            else if (dstreak != SW'(FAIR_LIMIT))
              dstreak <= dstreak + 1'b1;
          end
          default: dstreak <= '0;
        endcase
      end else if (!ramready && !expired) begin
        wcnt <= wcnt + 1'b1;
      end
      if (granted && expired)
        errQ <= 1'b1;
    end
  end

  assign ramaddr     = addrQ;
  assign ramstore    = storeQ;
  assign busy        = granted;
  assign timeout_err = errQ;
  assign iload       = ramload;
  assign dload       = ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors for the fetch/data RAM arbiter.
// FAIR_LIMIT=4, TIMEOUT=8.
module tb_mem_arbiter;

  logic        CLK;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] ramload;
  logic        ramready;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic        ihit;
  logic        dhit;
  logic [31:0] iload;
  logic [31:0] dload;
  logic        busy;
  logic        timeout_err;

  int total;
  int bad;

  mem_arbiter #(
    .FAIR_LIMIT(4),
    .TIMEOUT(8)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .iREN(iREN),
    .iaddr(iaddr),
    .dREN(dREN),
    .dWEN(dWEN),
    .daddr(daddr),
    .dstore(dstore),
    .ramload(ramload),
    .ramready(ramready),
    .ramREN(ramREN),
    .ramWEN(ramWEN),
    .ramaddr(ramaddr),
    .ramstore(ramstore),
    .ihit(ihit),
    .dhit(dhit),
    .iload(iload),
    .dload(dload),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic nxt;
    @(posedge CLK);
    #1;
  endtask

  task automatic smp;
    @(negedge CLK);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    nRST     = 1'b0;
    iREN     = 1'b0;
    iaddr    = '0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    daddr    = '0;
    dstore   = '0;
    ramload  = 32'h1234_5678;
    ramready = 1'b0;

    nxt;
    nxt;
    smp;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ren", 32'(ramREN), 32'd0);
    chk("rst_wen", 32'(ramWEN), 32'd0);
    chk("rst_addr", ramaddr, 32'd0);
    chk("rst_store", ramstore, 32'd0);
    chk("rst_ihit", 32'(ihit), 32'd0);
    chk("rst_dhit", 32'(dhit), 32'd0);
    chk("rst_err", 32'(timeout_err), 32'd0);
    chk("rst_iload", iload, 32'h1234_5678);
    chk("rst_dload", dload, 32'h1234_5678);
    nRST = 1'b1;
    nxt;

    // isolated fetch, ready 3 cycles after grant
    iREN    = 1'b1;
    iaddr   = 32'h40;
    ramload = 32'h8C22_0004;
    smp;
    chk("f_idle", 32'(busy), 32'd0);
    nxt;
    for (int g = 0; g < 3; g++) begin
      if (g == 1) iaddr = 32'h44;
      smp;
      chk("f_ren", 32'(ramREN), 32'd1);
      chk("f_addr", ramaddr, 32'h40);
      chk("f_nohit", 32'(ihit), 32'd0);
      nxt;
    end
    ramready = 1'b1;
    smp;
    chk("f_ihit", 32'(ihit), 32'd1);
    chk("f_iload", iload, 32'h8C22_0004);
    nxt;
    iREN     = 1'b0;
    ramready = 1'b0;
    smp;
    chk("f_post_ihit", 32'(ihit), 32'd0);
    chk("f_post_busy", 32'(busy), 32'd0);
    chk("f_post_ren", 32'(ramREN), 32'd0);
    nxt;

    // simultaneous fetch + data write: data first
    iREN     = 1'b1;
    iaddr    = 32'h80;
    dWEN     = 1'b1;
    daddr    = 32'h100;
    dstore   = 32'hDEAD_BEEF;
    ramready = 1'b1;
    smp;
    chk("s_idle", 32'(busy), 32'd0);
    nxt;
    smp;
    chk("s_wen", 32'(ramWEN), 32'd1);
    chk("s_ren", 32'(ramREN), 32'd0);
    chk("s_store", ramstore, 32'hDEAD_BEEF);
    chk("s_addr", ramaddr, 32'h100);
    chk("s_dhit", 32'(dhit), 32'd1);
    chk("s_noihit", 32'(ihit), 32'd0);
    nxt;
    dWEN = 1'b0;
    smp;
    chk("s_gap_busy", 32'(busy), 32'd0);
    chk("s_gap_dhit", 32'(dhit), 32'd0);
    nxt;
    smp;
    chk("s_iren", 32'(ramREN), 32'd1);
    chk("s_iaddr", ramaddr, 32'h80);
    chk("s_ihit", 32'(ihit), 32'd1);
    nxt;
    iREN = 1'b0;
    smp;
    chk("s_end_busy", 32'(busy), 32'd0);
    nxt;

    // fairness: 4 data grants, then the waiting fetch
    iREN     = 1'b1;
    iaddr    = 32'h84;
    dREN     = 1'b1;
    daddr    = 32'h200;
    ramready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      smp;
      chk($sformatf("fair_dhit%0d", c), 32'(dhit),
          32'((c % 2 == 1) && (c != 9)));
      chk($sformatf("fair_ihit%0d", c), 32'(ihit), 32'(c == 9));
      nxt;
      if (c == 9) iREN = 1'b0;
    end
    dREN = 1'b0;
    smp;
    chk("fair_end_busy", 32'(busy), 32'd0);
    nxt;

    // abort: fetch dropped before ready
    iREN     = 1'b1;
    iaddr    = 32'h200;
    ramready = 1'b0;
    smp;
    nxt;
    smp;
    chk("ab_ren", 32'(ramREN), 32'd1);
    iREN = 1'b0;
    nxt;
    ramready = 1'b1;
    smp;
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_ren_lo", 32'(ramREN), 32'd0);
    chk("ab_ihit", 32'(ihit), 32'd0);
    ramready = 1'b0;
    nxt;

    // watchdog: data read never ready
    dREN  = 1'b1;
    daddr = 32'h300;
    smp;
    chk("to_idle", 32'(busy), 32'd0);
    nxt;
    for (int k = 0; k <= 8; k++) begin
      smp;
      chk($sformatf("to_busy%0d", k), 32'(busy), 32'd1);
      chk($sformatf("to_dhit%0d", k), 32'(dhit), 32'd0);
      chk($sformatf("to_err%0d", k), 32'(timeout_err), 32'd0);
      nxt;
    end
    dREN = 1'b0;
    smp;
    chk("to_abort_busy", 32'(busy), 32'd0);
    chk("to_abort_ren", 32'(ramREN), 32'd0);
    chk("to_err_set", 32'(timeout_err), 32'd1);
    nxt;
    dREN     = 1'b1;
    daddr    = 32'h304;
    ramready = 1'b1;
    smp;
    nxt;
    smp;
    chk("to_next_dhit", 32'(dhit), 32'd1);
    chk("to_next_ren", 32'(ramREN), 32'd1);
    chk("to_err_sticky", 32'(timeout_err), 32'd1);
    nxt;
    dREN     = 1'b0;
    ramready = 1'b0;
    smp;
    chk("to_err_sticky2", 32'(timeout_err), 32'd1);
    nxt;

    // reset during a data grant
    dREN  = 1'b1;
    daddr = 32'h400;
    smp;
    nxt;
    smp;
    chk("mr_busy", 32'(busy), 32'd1);
    chk("mr_addr", ramaddr, 32'h400);
    nRST = 1'b0;
    nxt;
    nRST = 1'b1;
    smp;
    chk("mr_busy0", 32'(busy), 32'd0);
    chk("mr_ren0", 32'(ramREN), 32'd0);
    chk("mr_wen0", 32'(ramWEN), 32'd0);
    chk("mr_addr0", ramaddr, 32'd0);
    chk("mr_store0", ramstore, 32'd0);
    chk("mr_dhit0", 32'(dhit), 32'd0);
    chk("mr_ihit0", 32'(ihit), 32'd0);
    chk("mr_err0", 32'(timeout_err), 32'd0);
    nxt;
    ramready = 1'b1;
    smp;
    chk("mr_regrant", 32'(busy), 32'd1);
    chk("mr_readdr", ramaddr, 32'h400);
    chk("mr_dhit", 32'(dhit), 32'd1);
    nxt;
    dREN     = 1'b0;
    ramready = 1'b0;
    nxt;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
